vga_timing_reader: RTL and testbench

VGA_TIMING_READER -- requirements
Module: vga_timing_reader

---
 rtl/vga_timing_reader.sv | 83 ++++++++
 tb/tb_vga_timing_reader.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/vga_timing_reader.sv
// vga_timing_reader: VGA raster timing that requests pixels from a double buffer and drives the DAC one cycle later
module vga_timing_reader #(
    parameter int H_ACTIVE = 640,
    parameter int H_FRONT  = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BACK   = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FRONT  = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BACK   = 33
) (
    input  logic       clk,
    input  logic       reset,
    output logic       readEnable,
    input  logic [7:0] inRed,
    input  logic [7:0] inGreen,
    input  logic [7:0] inBlue,
    output logic [7:0] vgaRed,
    output logic [7:0] vgaGreen,
    output logic [7:0] vgaBlue,
    output logic       hsync,
    output logic       vsync,
    output logic       blankN,
    output logic       frameStart,
    output logic [9:0] pixelX,
    output logic [9:0] pixelY
);
    typedef enum logic [1:0] {ACTIVE, FRONT, SYNC, BACK} region_t;
    localparam logic [9:0] H_A_END = 10'(H_ACTIVE - 1);
    localparam logic [9:0] H_F_END = 10'(H_ACTIVE + H_FRONT - 1);
    localparam logic [9:0] H_S_END = 10'(H_ACTIVE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] H_LAST  = 10'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_A_END = 10'(V_ACTIVE - 1);
    localparam logic [9:0] V_F_END = 10'(V_ACTIVE + V_FRONT - 1);
    localparam logic [9:0] V_S_END = 10'(V_ACTIVE + V_FRONT + V_SYNC - 1);
    localparam logic [9:0] V_LAST  = 10'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
    logic [9:0] h_count, v_count;
    logic       h_wrap;
    region_t    h_state, v_state;
    function automatic region_t next_region(input region_t s, input logic [9:0] c,
                                            input logic [9:0] a_end, input logic [9:0] f_end,
                                            input logic [9:0] s_end, input logic [9:0] last);
        return (s == ACTIVE && c == a_end) ? FRONT :
               (s == FRONT  && c == f_end) ? SYNC  :
               (s == SYNC   && c == s_end) ? BACK  :
               (s == BACK   && c == last)  ? ACTIVE : s;
    endfunction
    always_comb begin
        h_wrap     = h_count == H_LAST;
        readEnable = reset && h_state == ACTIVE && v_state == ACTIVE;
        frameStart = reset && h_count == '0 && v_count == '0;
        pixelX     = h_count;
        pixelY     = v_count;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            h_count  <= '0;
            v_count  <= '0;
            h_state  <= ACTIVE;
            v_state  <= ACTIVE;
            hsync    <= 1'b1;
            vsync    <= 1'b1;
            blankN   <= 1'b0;
            vgaRed   <= '0;
            vgaGreen <= '0;
            vgaBlue  <= '0;
        end else begin
            h_count <= h_wrap ? '0 : h_count + 10'd1;
            h_state <= next_region(h_state, h_count, H_A_END, H_F_END, H_S_END, H_LAST);
            if (h_wrap) begin
                v_count <= (v_count == V_LAST) ? '0 : v_count + 10'd1;
                v_state <= next_region(v_state, v_count, V_A_END, V_F_END, V_S_END, V_LAST);
            end
            // buffer data arrives one cycle after the request, so sync and blank are delayed to match
            hsync    <= h_state != SYNC;
            vsync    <= v_state != SYNC;
            blankN   <= readEnable;
            vgaRed   <= readEnable ? inRed   : '0;
            vgaGreen <= readEnable ? inGreen : '0;
            vgaBlue  <= readEnable ? inBlue  : '0;
        end
    end
endmodule

// File: tb/tb_vga_timing_reader.sv
// tb_vga_timing_reader: frame-index model checked every cycle, plus literal timing checks on a small raster
module tb_vga_timing_reader;
    localparam int HA = 8, HF = 2, HS = 2, HB = 2, VA = 4, VF = 1, VS = 1, VB = 1;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;
    logic       clk = 0, reset = 0;
    logic [7:0] inRed = 0, inGreen = 0, inBlue = 0;
    logic       readEnable, hsync, vsync, blankN, frameStart;
    logic [7:0] vgaRed, vgaGreen, vgaBlue;
    logic [9:0] pixelX, pixelY;
    int n_checks = 0, n_err = 0, cyc = 0;
    vga_timing_reader #(
        .H_ACTIVE(HA), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_ACTIVE(VA), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clk(clk), .reset(reset), .readEnable(readEnable),
        .inRed(inRed), .inGreen(inGreen), .inBlue(inBlue),
        .vgaRed(vgaRed), .vgaGreen(vgaGreen), .vgaBlue(vgaBlue),
        .hsync(hsync), .vsync(vsync), .blankN(blankN), .frameStart(frameStart),
        .pixelX(pixelX), .pixelY(pixelY)
    );
    always #5 clk = ~clk;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask
    logic       armed = 0;
    int         m_t = 0, m_h, m_v;
    logic       m_re, e_hs, e_vs, e_bl;
    logic [7:0] e_r, e_g, e_b;
    assign m_h  = m_t % HT;
    assign m_v  = m_t / HT;
    assign m_re = m_h < HA && m_v < VA;
    always @(posedge clk) begin
        if (!reset) begin
            armed <= 1;
            m_t   <= 0;
            e_hs  <= 1;
            e_vs  <= 1;
            e_bl  <= 0;
            e_r   <= 0;
            e_g   <= 0;
            e_b   <= 0;
        end else begin
            e_hs <= !(m_h >= HA + HF && m_h < HA + HF + HS);
            e_vs <= !(m_v >= VA + VF && m_v < VA + VF + VS);
            e_bl <= m_re;
            e_r  <= m_re ? inRed : 8'h00;
            e_g  <= m_re ? inGreen : 8'h00;
            e_b  <= m_re ? inBlue : 8'h00;
            m_t  <= (m_t + 1) % FRAME;
        end
    end
    always @(negedge clk) begin
        if (armed) begin
            check("readEnable", readEnable, reset && m_re);
            check("frameStart", frameStart, reset && m_t == 0);
            check("hsync", hsync, e_hs);
            check("vsync", vsync, e_vs);
            check("blankN", blankN, e_bl);
            check("vgaRed", vgaRed, e_r);
            check("vgaGreen", vgaGreen, e_g);
            check("vgaBlue", vgaBlue, e_b);
            if (reset && m_re) begin
                check("pixelX", pixelX, m_h);
                check("pixelY", pixelY, m_v);
            end
        end
    end
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        inRed   = 8'(cyc) | 8'h01;
        inGreen = ~8'(cyc);
        inBlue  = 8'(cyc * 3) ^ 8'h5A;
    endtask
    task automatic run_to(input int target);
        int n = 0;
        while (m_t != target && n < 4 * FRAME) begin
            tick();
            n++;
        end
        if (m_t != target) check("run_to timeout", m_t, target);
    endtask
    initial begin
        int re_cnt = 0, hs_cnt = 0, vs_cnt = 0, fs_cnt = 0, hs_first = -1, vs_first = -1;
        logic [7:0] r0 = 0;
        repeat (3) tick();
        reset = 1;
        for (int k = 0; k < 99; k++) begin
            @(negedge clk);
            if (k == 0) begin
                check("first readEnable", readEnable, 1);
                check("first frameStart", frameStart, 1);
                check("first pixelX", pixelX, 0);
                check("first pixelY", pixelY, 0);
                r0 = inRed;
            end
            if (k == 1) check("first pixel out", vgaRed, r0);
            if (k == 9) check("first blank rgb", vgaRed, 0);
            if (k == 98) begin
                check("wrap frameStart", frameStart, 1);
                check("wrap readEnable", readEnable, 1);
                check("wrap pixelX", pixelX, 0);
                check("wrap pixelY", pixelY, 0);
            end else begin
                re_cnt += int'(readEnable);
                fs_cnt += int'(frameStart);
                if (!hsync) begin
                    hs_cnt++;
                    if (hs_first < 0) hs_first = k;
                end
                if (!vsync) begin
                    vs_cnt++;
                    if (vs_first < 0) vs_first = k;
                end
            end
            tick();
        end
        check("requests per frame", re_cnt, 32);
        check("frameStart per frame", fs_cnt, 1);
        check("hsync first low", hs_first, 11);
        check("hsync low cycles", hs_cnt, 14);
        check("vsync first low", vs_first, 71);
        check("vsync low cycles", vs_cnt, 14);
        run_to(31);
        reset = 0;
        @(negedge clk);
        check("rst readEnable", readEnable, 0);
        check("rst frameStart", frameStart, 0);
        tick();
        reset = 1;
        @(negedge clk);
        check("post-rst hsync", hsync, 1);
        check("post-rst vsync", vsync, 1);
        check("post-rst blankN", blankN, 0);
        check("post-rst vgaRed", vgaRed, 0);
        check("post-rst pixelX", pixelX, 0);
        check("post-rst pixelY", pixelY, 0);
        check("post-rst frameStart", frameStart, 1);
        check("post-rst readEnable", readEnable, 1);
        run_to(25);
        @(negedge clk);
        check("hsync low before rst", hsync, 0);
        reset = 0;
        tick();
        reset = 1;
        @(negedge clk);
        check("hsync after rst", hsync, 1);
        run_to(72);
        @(negedge clk);
        check("vsync low before rst", vsync, 0);
        reset = 0;
        tick();
        reset = 1;
        @(negedge clk);
        check("vsync after rst", vsync, 1);
        repeat (2 * FRAME) tick();
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
